// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Width of the consecutive-grant counter; wide enough for MAX_HOLD up to 15.
    localparam int HOLD_W = 4;

endpackage

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the load/store path (port 0)
// and the debug/DMA port (port 1). Ownership is sticky, but an owner is
// pre-empted after MAX_HOLD back-to-back grants while the other port waits.
//
// state | meaning
// IDLE  | no access granted last cycle
// OWN0  | port 0 was granted last cycle
// OWN1  | port 1 was granted last cycle
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_t        state, state_nxt;
    logic              last, last_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              grant_any;
    logic              grant_sel;

    // Grant decision; reset masks grants so an access in flight is discarded.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (reset) begin
            if (req0 && req1) begin
                grant_any = 1'b1;
                case (state)
                    OWN0:    grant_sel = (hold_cnt < HOLD_MAX) ? 1'b0 : 1'b1;
                    OWN1:    grant_sel = (hold_cnt < HOLD_MAX) ? 1'b1 : 1'b0;
                    default: grant_sel = ~last;
                endcase
            end else if (req0 || req1) begin
                grant_any = 1'b1;
                grant_sel = req1;
            end
        end
    end

    assign gnt0 = grant_any & ~grant_sel;
    assign gnt1 = grant_any &  grant_sel;

    // Next owner, last-owner tie-breaker and saturating hold counter.
    always_comb begin
        state_nxt = IDLE;
        last_nxt  = last;
        hold_nxt  = '0;
        if (grant_any) begin
            state_nxt = grant_sel ? OWN1 : OWN0;
            last_nxt  = grant_sel;
            if (state_nxt == state)
                hold_nxt = (hold_cnt < HOLD_MAX) ? hold_cnt + HOLD_ONE : HOLD_MAX;
            else
                hold_nxt = HOLD_ONE;
        end
    end

    // Memory port follows the granted requester; quiet when nothing is granted.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (gnt0) begin
            mem_we = we0;
            mem_a  = addr0;
            mem_wd = wdata0;
        end else if (gnt1) begin
            mem_we = we1;
            mem_a  = addr1;
            mem_wd = wdata1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Read return: capture memory data for a granted read, one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0)
                rdata0 <= mem_rd;
            if (gnt1 && !we1)
                rdata1 <= mem_rd;
        end
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port data memory between requester 0 (processor load/store path) and requester 1 (debug/DMA port). It grants at most one access per cycle, drives the memory's write-enable, address and write-data, and returns read data to the granted requester one cycle later. Ownership is sticky with a bounded hold (`MAX_HOLD`) so neither requester can starve the other.

## Interface
- `DATA_WIDTH`, 32: word width of memory data.
- `ADDR_WIDTH`, 32: address width driven to memory.
- `MAX_HOLD`, 4: maximum consecutive grants to one owner while the other requester is waiting; legal range 1..15.

- `clk`  in  1: sole clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `req0`, `req1`  in  1: access request; held with its `we`/`addr`/`wdata` stable until the matching `gnt` is seen high.
- `we0`, `we1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_WIDTH: word address.
- `wdata0`, `wdata1`  in  DATA_WIDTH: write data.
- `gnt0`, `gnt1`  out  1: combinational grant, at most one high per cycle; the access completes at the following edge.
- `rvalid0`, `rvalid1`  out  1: registered; high for exactly one cycle after a granted read.
- `rdata0`, `rdata1`  out  DATA_WIDTH: registered read data, valid while the matching `rvalid` is high, held otherwise.
- `mem_we`  out  1: memory write enable.
- `mem_a`  out  ADDR_WIDTH: memory address.
- `mem_wd`  out  DATA_WIDTH: memory write data.
- `mem_rd`  in  DATA_WIDTH: memory combinational read data for `mem_a`.

## Operation
- **FSM states**
  - IDLE: no owner.
  - OWN0: owner is requester 0.
  - OWN1: owner is requester 1.
- **Registers**
  - `last`: last owner; reset value 1, so requester 0 wins the first tie.
  - `hold_cnt`: 4 bits; reset value 0.
- **Grant decision** (combinational, from state and requests):
  - Neither request: no grant; next state IDLE; `hold_cnt` 0.
  - Only one request: grant it.
  - IDLE with both requests: grant `!last`.
  - OWNx with both requests:
    - Keep x while `hold_cnt < MAX_HOLD`.
    - Otherwise grant the other requester.
  - OWNx with only the other requester requesting: switch immediately.
- **On grant to y:**
  - Next state OWNy; `last` becomes y.
  - `hold_cnt` becomes `hold_cnt+1` if y equals the current owner, else 1. Saturates at `MAX_HOLD`.
- **Memory drive**
  - `mem_a`, `mem_wd` and `mem_we` come from the granted port's `addr`, `wdata` and `we`.
  - With no grant, `mem_we` is 0 and `mem_a`/`mem_wd` are 0.
- **Read return:** a granted read captures `mem_rd` into `rdataY` at the edge and sets `rvalidY` for one cycle.
- **Write return:** a granted write produces no `rvalid`.
- **Reset values:**
  - `gnt0`/`gnt1` are 0 and `mem_we` is 0 while `reset` is low.
  - `rvalid` 0, `rdata` 0, state IDLE.
  - Reset asserted mid-access discards that access: no write occurs and no `rvalid` follows.

## Timing
- Grant is same-cycle combinational from `req` (no registered request path).
- Throughput: one access per cycle, back-to-back grants allowed.
- Read latency: `rvalid` 1 cycle after the `gnt` cycle.
- Write commits at the edge ending the `gnt` cycle.
- A write to address A granted in cycle n, followed by a read of A granted in cycle n+1, returns the new data.
- A non-granted requester keeps its request held; the arbiter never drops it.
- Worst-case wait for a requester under contention: `MAX_HOLD` cycles.
- Simultaneous `req` deassert by the owner and assert by the other: grant the other in that cycle.

## Structure
- Shared package: the state encoding `arb_state_t` (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the hold-counter width constant.
- Flat block; no sub-module. A separate 2:1 port mux is not warranted.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `req0`=`req1`=1 -> `gnt0`=`gnt1`=0, `mem_we`=0, `rvalid`=0, `rdata`=0. Release -> `gnt0`=1 in the first cycle.
- **Single write then read:** requester 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> `mem_we`=1 in cycle 1; next cycle `rvalid0`=1, `rdata0`=0xDEADBEEF, `rvalid1`=0.
- **Contention with `MAX_HOLD`=4:** both request continuously -> grant sequence 0,0,0,0,1,1,1,1,0…; never more than 4 consecutive grants to one side.
- **Switch on idle owner:** `req0` stops while `req1` is asserted in the same cycle -> `gnt1`=1 that cycle and `hold_cnt` restarts at 1.
- **Cross-port coherence:** requester 1 writes 0x00000077 to addr 3; requester 0 reads addr 3 in the next cycle -> `rdata0`=0x00000077.
- **Reset mid-read:** assert `reset` in the grant cycle of a read by requester 1 -> no `rvalid1` follows and the state returns to IDLE.
